uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Frame serializer for the UART transmit path. It drains bytes from the transmit FIFO through the FIFO's read port (`read_enable` / `data_out` / `empty`) and shifts each byte onto the serial line. Each byte goes out as start bit, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits, at a fixed clock-to-bit ratio. It is the consumer at the FIFO's read end; the FIFO's write end stays with the host.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `PARITY`, default 0: 0 = no parity bit, 1 = even parity, 2 = odd parity.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.

Ports:
- `clock`  in  1: single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `tx_enable`  in  1: when low, no new frame starts; a frame already in flight completes.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data`  in  8: FIFO `data_out`, combinational read of the head entry.
- `fifo_read_enable`  out  1: pop strobe to the FIFO `read_enable`, 1 cycle per byte.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is on the line.
- `frame_done`  out  1: 1-cycle pulse on the last cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when `PARITY`=0.
  - STOP lasts `STOP_BITS` × `CLKS_PER_BIT` cycles.
- Registers:
  - `shift_reg[7:0]`: the byte being sent.
  - `bit_cnt[2:0]`: data bit index.
  - `baud_cnt`: width clog2(`CLKS_PER_BIT`), counts 0..`CLKS_PER_BIT`−1 and wraps to 0.
  - `stop_cnt`: 1 bit.
  - `parity_bit`: 1 bit.
- Load condition: `load` = ~`reset` & `tx_enable` & ~`fifo_empty` & (state==IDLE | last cycle of STOP).
- `fifo_read_enable` = `load`. It is combinational and never asserted while `fifo_empty`=1.
- On `load`:
  - `shift_reg` <= `fifo_data`.
  - `parity_bit` <= ^`fifo_data` for even parity, or ~^`fifo_data` for odd parity.
  - `baud_cnt` <= 0.
  - Next state is START.
- State sequence:
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx`=`shift_reg[0]`. When `baud_cnt` wraps, `shift_reg` shifts right and `bit_cnt` increments. After bit 7 wraps, go to PARITY, or to STOP when there is no parity.
  - PARITY: `tx`=`parity_bit` for `CLKS_PER_BIT` cycles.
  - STOP: `tx`=1. On the final STOP cycle, `frame_done`=1. Next state is START if `load`, otherwise IDLE.
- Back-to-back frames: no idle-high gap is inserted between frames when the FIFO is non-empty and `tx_enable`=1.
- `tx_enable` low: `tx_enable` is sampled only at `load` points. Lowering it mid-frame does not truncate the frame.
- `busy`=1 in START, DATA, PARITY and STOP; `busy`=0 in IDLE.
- `tx` is driven from a register, so it is glitch-free.

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `frame_done`=0, `fifo_read_enable`=0, and all counters 0.
- Latency: `tx` falls 1 cycle after the `load` edge. With `fifo_empty` low and the serializer idle, `fifo_read_enable` is high in cycle N and `tx`=0 from cycle N+1.
- Frame length: exactly (1 + 8 + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P = (`PARITY`≠0).
- Pop timing: the FIFO read pointer advances on the same edge that `fifo_data` is captured into `shift_reg`, so no extra read latency is needed.
- Empty during STOP: if `fifo_empty`=1 on the last STOP cycle, go to IDLE. A byte arriving later starts a frame 1 cycle after `fifo_empty` falls.
- Reset mid-frame: on the next edge, `tx`=1, `busy`=0 and state=IDLE. The partially sent byte is discarded and not re-read. `fifo_read_enable` is forced to 0 while `reset`=1.
- Simultaneous reset and `load`: reset wins, and no pop occurs.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, `PARITY`=0, `STOP_BITS`=1, FIFO holds 0xA5:
  - one `fifo_read_enable` pulse;
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each value held for 4 cycles (40 cycles total);
  - `frame_done` pulses on cycle 40;
  - `busy` falls after that.
- Parity, byte 0xA5 (4 ones):
  - with `PARITY`=1, the parity bit is 0;
  - with `PARITY`=2, the parity bit is 1;
  - frame is 44 cycles at `CLKS_PER_BIT`=4.
- Back-to-back, FIFO preloaded with 0x01, 0x02, 0x03:
  - three pops, each on the last STOP cycle of the previous frame;
  - `tx` is never high longer than the stop bit between frames;
  - total 120 cycles, then `fifo_empty`=1, IDLE, `tx`=1.
- `tx_enable` low mid-frame with 2 bytes queued: the current frame completes, no second pop occurs, and the second frame starts 1 cycle after `tx_enable` returns high.
- Reset asserted during DATA bit 3: next cycle `tx`=1, `busy`=0 and `fifo_read_enable`=0. The following frame sends the next FIFO byte from the start bit.
- `STOP_BITS`=2, byte 0xFF: the stop period is 8 cycles at `CLKS_PER_BIT`=4, and `frame_done` pulses only on the 8th stop cycle.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit-side UART frame serializer. Pops bytes from the read port of the
// transmit FIFO and shifts each one onto the serial line as:
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
// Each bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clock             rising-edge clock
//   reset             synchronous, active-high reset
//   tx_enable         gates the start of new frames; a frame in flight finishes
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO head entry (combinational read)
//   fifo_read_enable  FIFO pop strobe, one cycle per byte
//   tx                serial line, idle high, driven from a register
//   busy              high while a frame is on the line
//   frame_done        one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tx_enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_enable,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   // Value of stop_cnt during the final stop bit.
   localparam logic              STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t            state_reg,      state_next;
   logic [7:0]        shift_reg,      shift_next;
   logic [2:0]        bit_cnt_reg,    bit_cnt_next;
   logic [BAUD_W-1:0] baud_cnt_reg,   baud_cnt_next;
   logic              stop_cnt_reg,   stop_cnt_next;
   logic              parity_bit_reg, parity_bit_next;
   logic              tx_reg,         tx_next;

   logic baud_wrap;
   logic last_stop;
   logic load;

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      baud_cnt_next   = baud_cnt_reg;
      stop_cnt_next   = stop_cnt_reg;
      parity_bit_next = parity_bit_reg;
      tx_next         = 1'b1;

      baud_wrap = (baud_cnt_reg == BAUD_LAST);
      last_stop = (state_reg == ST_STOP) && baud_wrap && (stop_cnt_reg == STOP_LAST);

      // A new byte may be taken when idle or on the very last stop cycle, which
      // lets frames run back to back without an idle gap.
      load = ~reset & tx_enable & ~fifo_empty &
             ((state_reg == ST_IDLE) | last_stop);

      // The bit timer only runs while a frame is on the line.
      if (state_reg != ST_IDLE) begin
         baud_cnt_next = baud_wrap ? '0 : (baud_cnt_reg + BAUD_ONE);
      end

      case (state_reg)
         ST_START: begin
            if (baud_wrap) begin
               state_next   = ST_DATA;
               bit_cnt_next = 3'd0;
            end
         end
         ST_DATA: begin
            if (baud_wrap) begin
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  stop_cnt_next = 1'b0;
                  state_next    = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (baud_wrap) begin
               stop_cnt_next = 1'b0;
               state_next    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_wrap) begin
               if (stop_cnt_reg == STOP_LAST) begin
                  state_next = ST_IDLE;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase

      // Loading overrides the normal sequencing (including the STOP -> IDLE
      // transition on the last stop cycle).
      if (load) begin
         shift_next      = fifo_data;
         parity_bit_next = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
         baud_cnt_next   = '0;
         bit_cnt_next    = 3'd0;
         stop_cnt_next   = 1'b0;
         state_next      = ST_START;
      end

      // The line level is computed for the upcoming state so the register
      // output lines up with the state register.
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shift_next[0];
         ST_PARITY: tx_next = parity_bit_next;
         default:   tx_next = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         baud_cnt_reg   <= '0;
         stop_cnt_reg   <= 1'b0;
         parity_bit_reg <= 1'b0;
         tx_reg         <= 1'b1;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
         baud_cnt_reg   <= baud_cnt_next;
         stop_cnt_reg   <= stop_cnt_next;
         parity_bit_reg <= parity_bit_next;
         tx_reg         <= tx_next;
      end
   end

   assign fifo_read_enable = load;
   assign tx               = tx_reg;
   assign busy             = (state_reg != ST_IDLE);
   assign frame_done       = ~reset & last_stop;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Four serializer instances at CLKS_PER_BIT=4:
//   0: no parity, 1 stop    1: even parity    2: odd parity    3: 2 stop bits
// Each instance reads from a small FIFO model. Outputs are sampled on the
// falling clock edge and compared as whole-frame bit vectors (bit k = k-th
// cycle after the pop cycle).
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   logic       clk;
   logic       reset;
   logic [3:0] en;
   logic [3:0] empty_w;
   logic [3:0] rd_w;
   logic [3:0] tx_w;
   logic [3:0] busy_w;
   logic [3:0] done_w;
   logic [7:0] data_w [4];

   logic [7:0] mem [4][8];
   int         wr_ptr [4];
   int         rd_ptr [4];

   int errors = 0;
   int checks = 0;

   logic [127:0] cap_tx, cap_busy, cap_done, cap_rd;
   logic [127:0] want;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dut
         assign data_w[gi]  = mem[gi][rd_ptr[gi] & 7];
         assign empty_w[gi] = (wr_ptr[gi] == rd_ptr[gi]);

         uart_tx_serializer #(
            .CLKS_PER_BIT (4),
            .PARITY       ((gi == 1) ? 1 : ((gi == 2) ? 2 : 0)),
            .STOP_BITS    ((gi == 3) ? 2 : 1)
         ) dut (
            .clock            (clk),
            .reset            (reset),
            .tx_enable        (en[gi]),
            .fifo_empty       (empty_w[gi]),
            .fifo_data        (data_w[gi]),
            .fifo_read_enable (rd_w[gi]),
            .tx               (tx_w[gi]),
            .busy             (busy_w[gi]),
            .frame_done       (done_w[gi])
         );
      end
   endgenerate

   // FIFO model read side: pointer advances on the pop edge.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd_w[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      end
   end

   task automatic push(input int inst, input logic [7:0] b);
      mem[inst][wr_ptr[inst] & 7] = b;
      wr_ptr[inst] = wr_ptr[inst] + 1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // Record n consecutive cycles of one instance, sampled on falling edges.
   task automatic capture(input int inst, input int n);
      cap_tx   = '0;
      cap_busy = '0;
      cap_done = '0;
      cap_rd   = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cap_tx[k]   = tx_w[inst];
         cap_busy[k] = busy_w[inst];
         cap_done[k] = done_w[inst];
         cap_rd[k]   = rd_w[inst];
      end
   endtask

   // seq lists line levels in send order (first bit = seq[nbits-1]); each
   // level is held for 4 cycles.
   function automatic logic [127:0] expand(input logic [15:0] seq, input int nbits);
      logic [127:0] v = '0;
      for (int i = 0; i < nbits; i++)
         for (int c = 0; c < 4; c++)
            v[i*4 + c] = seq[nbits-1-i];
      return v;
   endfunction

   function automatic logic [127:0] ones(input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [127:0] bit_at(input int p);
      logic [127:0] v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   // Hand-derived frames (start, data LSB first, [parity], stop)
   localparam logic [15:0] F_A5      = 16'b0101001011;   // 0xA5, no parity
   localparam logic [15:0] F_A5_EVEN = 16'b01010010101;  // parity bit 0
   localparam logic [15:0] F_A5_ODD  = 16'b01010010111;  // parity bit 1
   localparam logic [15:0] F_FF_2S   = 16'b01111111111;  // 0xFF, 2 stop bits
   localparam logic [15:0] F_01      = 16'b0100000001;
   localparam logic [15:0] F_02      = 16'b0010000001;
   localparam logic [15:0] F_03      = 16'b0110000001;

   initial begin
      for (int i = 0; i < 4; i++) begin
         wr_ptr[i] = 0;
         rd_ptr[i] = 0;
         for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
      end
      reset = 1'b1;
      en    = 4'hF;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx",   128'(tx_w),   128'(4'hF));
      check("reset_busy", 128'(busy_w), 128'(4'h0));
      check("reset_done", 128'(done_w), 128'(4'h0));
      check("reset_rd",   128'(rd_w),   128'(4'h0));
      reset = 1'b0;
      @(negedge clk);
      check("idle_empty_rd", 128'(rd_w), 128'(4'h0));

      // ---------------- single byte 0xA5 ----------------
      push(0, 8'hA5);
      #1;
      check("single_pop", 128'(rd_w[0]), 128'(1'b1));
      capture(0, 41);
      check("single_tx",   cap_tx,   expand(F_A5, 10) | bit_at(40));
      check("single_busy", cap_busy, ones(40));
      check("single_done", cap_done, bit_at(39));
      check("single_rd",   cap_rd,   '0);

      // ---------------- back-to-back 0x01 0x02 0x03 ----------------
      push(0, 8'h01);
      push(0, 8'h02);
      push(0, 8'h03);
      #1;
      check("b2b_pop0", 128'(rd_w[0]), 128'(1'b1));
      capture(0, 121);
      want = expand(F_01, 10) | (expand(F_02, 10) << 40) |
             (expand(F_03, 10) << 80) | bit_at(120);
      check("b2b_tx",    cap_tx,   want);
      check("b2b_busy",  cap_busy, ones(120));
      check("b2b_done",  cap_done, bit_at(39) | bit_at(79) | bit_at(119));
      check("b2b_rd",    cap_rd,   bit_at(39) | bit_at(79));
      check("b2b_empty", 128'(empty_w[0]), 128'(1'b1));

      // ---------------- tx_enable low mid-frame ----------------
      push(0, 8'h01);
      push(0, 8'h02);
      #1;
      check("en_pop0", 128'(rd_w[0]), 128'(1'b1));
      @(posedge clk);
      #1;
      en[0] = 1'b0;
      capture(0, 45);
      check("en_tx1",   cap_tx,   expand(F_01, 10) | (ones(45) & ~ones(40)));
      check("en_busy1", cap_busy, ones(40));
      check("en_done1", cap_done, bit_at(39));
      check("en_rd1",   cap_rd,   '0);
      en[0] = 1'b1;
      #1;
      check("en_pop1", 128'(rd_w[0]), 128'(1'b1));
      capture(0, 40);
      check("en_tx2",   cap_tx,   expand(F_02, 10));
      check("en_done2", cap_done, bit_at(39));

      // ---------------- reset during DATA bit 3 ----------------
      push(0, 8'hA5);
      push(0, 8'h03);
      #1;
      check("rst_pop0", 128'(rd_w[0]), 128'(1'b1));
      capture(0, 18);
      check("rst_pre_tx",   cap_tx,   expand(F_A5, 10) & ones(18));
      check("rst_pre_busy", cap_busy, ones(18));
      reset = 1'b1;
      capture(0, 1);
      check("rst_tx",   cap_tx,   128'(1'b1));
      check("rst_busy", cap_busy, '0);
      check("rst_rd",   cap_rd,   '0);
      check("rst_fifo_kept", 128'(empty_w[0]), 128'(1'b0));
      reset = 1'b0;
      #1;
      check("rst_pop1", 128'(rd_w[0]), 128'(1'b1));
      capture(0, 40);
      check("rst_next_tx",   cap_tx,   expand(F_03, 10));
      check("rst_next_done", cap_done, bit_at(39));

      // ---------------- even parity ----------------
      push(1, 8'hA5);
      #1;
      check("even_pop", 128'(rd_w[1]), 128'(1'b1));
      capture(1, 45);
      check("even_tx",   cap_tx,   expand(F_A5_EVEN, 11) | bit_at(44));
      check("even_busy", cap_busy, ones(44));
      check("even_done", cap_done, bit_at(43));

      // ---------------- odd parity ----------------
      push(2, 8'hA5);
      #1;
      check("odd_pop", 128'(rd_w[2]), 128'(1'b1));
      capture(2, 45);
      check("odd_tx",   cap_tx,   expand(F_A5_ODD, 11) | bit_at(44));
      check("odd_done", cap_done, bit_at(43));

      // ---------------- two stop bits ----------------
      push(3, 8'hFF);
      #1;
      check("stop2_pop", 128'(rd_w[3]), 128'(1'b1));
      capture(3, 45);
      check("stop2_tx",   cap_tx,   expand(F_FF_2S, 11) | bit_at(44));
      check("stop2_busy", cap_busy, ones(44));
      check("stop2_done", cap_done, bit_at(43));
      check("stop2_rd",   cap_rd,   '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
